// File: rtl/sdspi_perf_pkg.sv
// Shared types and constants for the SD-SPI read performance monitor.
package sdspi_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [2:0] SEL_CYC    = 3'd0;
  localparam logic [2:0] SEL_BLK    = 3'd1;
  localparam logic [2:0] SEL_BYTE   = 3'd2;
  localparam logic [2:0] SEL_MIN    = 3'd3;
  localparam logic [2:0] SEL_MAX    = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;

  localparam logic [31:0] DEBUG_PAD = 32'hDEAD_BEEF;

  function automatic logic [31:0] status_word(input state_e st, input logic busy,
                                              input logic done, input logic timeout);
    return {st, 26'b0, busy, done, timeout, 1'b0};
  endfunction

endpackage

// File: rtl/sdspi_perf_monitor_sat_counter.sv
// Saturating up-counter: clr restarts at zero, and a coincident inc counts the
// current cycle as well, so clr+inc yields 1.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any condition so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    if (inc && (cnt_d != '1)) cnt_d = cnt_d + WIDTH'(1);
  end

  // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/sdspi_perf_monitor.sv
// Passive SD-SPI read performance monitor feeding the 32-bit debug display word.
// Define SDSPI_PERF_MINMAX_EN to build the min/max inter-block interval tracker.
module sdspi_perf_monitor
  import sdspi_perf_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          BLK_W       = 32,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic        byte_valid,
  input  logic        block_done,
  input  logic [2:0]  sel,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] debug
);

  localparam int TW = ((CNT_W > 32) ? CNT_W : 32) + 1;

  state_e      state_q, state_d;
  logic        start_prev_q, finish_prev_q;
  logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [31:0] debug_q, debug_d;

  logic        start_rise, finish_rise, in_run, meas_clr, tmo_hit;
  logic [TW-1:0] cyc_next_ext;

  logic [CNT_W-1:0] cyc_cnt, byte_cnt, min_int, max_int;
  logic [BLK_W-1:0] blk_cnt;

  assign start_rise  = start & ~start_prev_q;
  assign finish_rise = finish & ~finish_prev_q;
  assign in_run      = (state_q == ST_RUN);
  // A start edge while already running is ignored, so it must not clear the counters.
  assign meas_clr    = start_rise & ~in_run;

  // Extra headroom bit keeps the compare exact even when the counter is saturated.
  assign cyc_next_ext = TW'(cyc_cnt) + TW'(1);
  assign tmo_hit      = (TIMEOUT_CYC != '0) && (cyc_next_ext == TW'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:             if (start_rise) state_d = ST_RUN;
      ST_RUN: begin
        if (finish_rise)  state_d = ST_DONE;
        else if (tmo_hit) state_d = ST_TIMEOUT;
      end
      ST_DONE, ST_TIMEOUT: if (start_rise) state_d = ST_RUN;
    endcase
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      start_prev_q  <= 1'b0;
      finish_prev_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      debug_q       <= '0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start;
      finish_prev_q <= finish;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      debug_q       <= debug_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(meas_clr), .inc(in_run), .q(cyc_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_byte_cnt (
    .clk(clk), .rst(rst), .clr(meas_clr), .inc(in_run & byte_valid), .q(byte_cnt)
  );

  sat_counter #(.WIDTH(BLK_W)) u_blk_cnt (
    .clk(clk), .rst(rst), .clr(meas_clr), .inc(in_run & block_done), .q(blk_cnt)
  );

`ifdef SDSPI_PERF_MINMAX_EN
  logic             blk_evt;
  logic [CNT_W-1:0] int_cnt, min_int_q, min_int_d, max_int_q, max_int_d;

  assign blk_evt = in_run & block_done;

  // On a block the interval restarts at 1: the strobe cycle belongs to the next interval.
  sat_counter #(.WIDTH(CNT_W)) u_int_cnt (
    .clk(clk), .rst(rst), .clr(meas_clr | blk_evt), .inc(in_run), .q(int_cnt)
  );

  always_comb begin
    min_int_d = min_int_q;
    max_int_d = max_int_q;
    if (meas_clr) begin
      min_int_d = '1;
      max_int_d = '0;
    end else if (blk_evt) begin
      if (int_cnt < min_int_q) min_int_d = int_cnt;
      if (int_cnt > max_int_q) max_int_d = int_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_int_q <= '1;
      max_int_q <= '0;
    end else begin
      min_int_q <= min_int_d;
      max_int_q <= max_int_d;
    end
  end

  assign min_int = min_int_q;
  assign max_int = max_int_q;
`else
  assign min_int = '0;
  assign max_int = '0;
`endif

  always_comb begin
    debug_d = DEBUG_PAD;
    case (sel)
      SEL_CYC:    debug_d = 32'(cyc_cnt);
      SEL_BLK:    debug_d = 32'(blk_cnt);
      SEL_BYTE:   debug_d = 32'(byte_cnt);
      SEL_MIN:    debug_d = 32'(min_int);
      SEL_MAX:    debug_d = 32'(max_int);
      SEL_STATUS: debug_d = status_word(state_q, busy_q, done_q, timeout_q);
      default:    debug_d = DEBUG_PAD;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign debug   = debug_q;

endmodule

// File: tb/tb_sdspi_perf_monitor.sv
// Self-checking bench: two monitor instances (32-bit with a 1000-cycle timeout, 8-bit with
// timeout disabled) share stimulus and are compared every cycle to a timestamp-based model.
module tb_sdspi_perf_monitor;

  localparam int N = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_TMO = 3;

  logic        clk = 1'b0;
  logic        rst, start, finish, byte_valid, block_done;
  logic [2:0]  sel;
  logic        busy_a, done_a, timeout_a, busy_b, done_b, timeout_b;
  logic [31:0] debug_a, debug_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdspi_perf_monitor #(.CNT_W(32), .BLK_W(32), .TIMEOUT_CYC(32'd1000)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .byte_valid(byte_valid),
    .block_done(block_done), .sel(sel), .busy(busy_a), .done(done_a),
    .timeout(timeout_a), .debug(debug_a)
  );

  sdspi_perf_monitor #(.CNT_W(8), .BLK_W(8), .TIMEOUT_CYC(32'd0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .byte_valid(byte_valid),
    .block_done(block_done), .sel(sel), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .debug(debug_b)
  );

  // Reference model: counts derived from event timestamps, clipped at each instance's maximum.
  longint cmax [N] = '{64'd4294967295, 64'd255};
  longint tmo  [N] = '{64'd1000, 64'd0};
  int     m_st [N];
  longint m_t0 [N], m_ref [N], m_cyc [N], m_byte [N], m_blk [N], m_min [N], m_max [N];
  logic [31:0] m_dbg [N];
  longint now;
  logic   m_prev_start, m_prev_finish;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] exp_word(input int m, input logic [2:0] sl);
    case (sl)
      3'd0: return 32'(m_cyc[m]);
      3'd1: return 32'(m_blk[m]);
      3'd2: return 32'(m_byte[m]);
`ifdef SDSPI_PERF_MINMAX_EN
      3'd3: return 32'(m_min[m]);
      3'd4: return 32'(m_max[m]);
`else
      3'd3: return 32'h0;
      3'd4: return 32'h0;
`endif
      3'd5: return {2'(m_st[m]), 26'b0, m_st[m] == S_RUN, m_st[m] >= S_DONE,
                    m_st[m] == S_TMO, 1'b0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_reset();
    now = 0;
    m_prev_start = 1'b0;
    m_prev_finish = 1'b0;
    for (int m = 0; m < N; m++) begin
      m_st[m] = S_IDLE; m_t0[m] = 0; m_ref[m] = 0;
      m_cyc[m] = 0; m_byte[m] = 0; m_blk[m] = 0;
      m_min[m] = cmax[m]; m_max[m] = 0; m_dbg[m] = 32'h0;
    end
  endtask

  task automatic model_edge();
    logic s_rise, f_rise;
    longint iv;
    s_rise = start && !m_prev_start;
    f_rise = finish && !m_prev_finish;
    m_prev_start = start;
    m_prev_finish = finish;
    now++;
    for (int m = 0; m < N; m++) begin
      m_dbg[m] = exp_word(m, sel);
      if (m_st[m] == S_RUN) begin
        m_cyc[m] = sat(now - m_t0[m], cmax[m]);
        if (byte_valid) m_byte[m] = sat(m_byte[m] + 1, cmax[m]);
        if (block_done) begin
          m_blk[m] = sat(m_blk[m] + 1, cmax[m]);
          iv = sat(now - m_ref[m], cmax[m]);
          if (iv < m_min[m]) m_min[m] = iv;
          if (iv > m_max[m]) m_max[m] = iv;
          m_ref[m] = now;
        end
        if (f_rise) m_st[m] = S_DONE;
        else if (tmo[m] != 0 && (now - m_t0[m]) == tmo[m]) m_st[m] = S_TMO;
      end else if (s_rise) begin
        m_st[m] = S_RUN; m_t0[m] = now; m_ref[m] = now + 1;
        m_cyc[m] = 0; m_byte[m] = 0; m_blk[m] = 0;
        m_min[m] = cmax[m]; m_max[m] = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("debug_a", debug_a, m_dbg[0]);
    check("busy_a", 32'(busy_a), 32'(m_st[0] == S_RUN));
    check("done_a", 32'(done_a), 32'(m_st[0] >= S_DONE));
    check("timeout_a", 32'(timeout_a), 32'(m_st[0] == S_TMO));
    check("debug_b", debug_b, m_dbg[1]);
    check("busy_b", 32'(busy_b), 32'(m_st[1] == S_RUN));
    check("done_b", 32'(done_b), 32'(m_st[1] >= S_DONE));
    check("timeout_b", 32'(timeout_b), 32'(m_st[1] == S_TMO));
  endtask

  // Called at a falling edge: drive, predict the next rising edge, then check at the next fall.
  task automatic step(input logic s, input logic f, input logic bv, input logic bd,
                      input logic [2:0] sl);
    start = s; finish = f; byte_valid = bv; block_done = bd; sel = sl;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [2:0] rsel();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic rs, rf;
    rst = 1'b0; start = 1'b0; finish = 1'b0; byte_valid = 1'b0; block_done = 1'b0; sel = 3'd0;
    model_reset();

    // Reset state, then min_int reads back as all-ones one cycle after release.
    repeat (2) @(negedge clk);
    compare_all();
    check("t1_rst_debug", debug_a, 32'h0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
`ifdef SDSPI_PERF_MINMAX_EN
    check("t1_min_a", debug_a, 32'hFFFF_FFFF);
    check("t1_min_b", debug_b, 32'h0000_00FF);
`else
    check("t1_min_a", debug_a, 32'h0);
    check("t1_min_b", debug_b, 32'h0);
`endif

    // Three blocks 100 cycles apart, finish 400 cycles after start.
    step(1'b1, 1'b0, 1'b0, 1'b0, rsel());
    for (int k = 1; k <= 400; k++)
      step(1'b1, k == 400, (k >= 2) && (k <= 301), (k == 101) || (k == 201) || (k == 301),
           rsel());
    check("t2_done_a", 32'(done_a), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("t2_cyc_a", debug_a, 32'd400);
    check("t2_cyc_b", debug_b, 32'd255);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    check("t2_blk_a", debug_a, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    check("t2_byte_a", debug_a, 32'd300);
    check("t5_byte_sat_b", debug_b, 32'd255);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
`ifdef SDSPI_PERF_MINMAX_EN
    check("t2_min_a", debug_a, 32'd100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    check("t2_max_a", debug_a, 32'd100);
`else
    check("t2_min_a", debug_a, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    check("t2_max_a", debug_a, 32'd0);
`endif

    // Timeout after exactly 1000 run cycles on the 32-bit instance.
    step(1'b1, 1'b0, 1'b0, 1'b0, rsel());
    for (int k = 1; k <= 1000; k++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, rsel());
      if (k == 999) check("t3_pre_timeout", 32'(timeout_a), 32'd0);
    end
    check("t3_timeout_a", 32'(timeout_a), 32'd1);
    check("t3_busy_a", 32'(busy_a), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("t3_cyc_a", debug_a, 32'd1000);
    check("t3_cyc_b", debug_b, 32'd255);

    // Simultaneous start and finish edges while running: finish wins.
    step(1'b0, 1'b0, 1'b0, 1'b0, rsel());
    step(1'b1, 1'b0, 1'b0, 1'b0, rsel());
    repeat (20) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, rsel());
    step(1'b0, 1'b0, 1'b0, 1'b0, rsel());
    step(1'b1, 1'b1, 1'b1, 1'b1, rsel());
    check("t4_done_a", 32'(done_a), 32'd1);
    check("t4_done_b", 32'(done_b), 32'd1);
    check("t4_busy_a", 32'(busy_a), 32'd0);
    repeat (10) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsel());
    step(1'b0, 1'b0, 1'b0, 1'b0, rsel());
    step(1'b1, 1'b0, 1'b0, 1'b0, rsel());
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("t4_clr_cyc_a", debug_a, 32'd0);
    check("t4_clr_cyc_b", debug_b, 32'd0);

    // Asynchronous reset in the middle of a measurement.
    repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    check("t6_async_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    start = 1'b0; finish = 1'b0;
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
    check("t6_idle_byte_a", debug_a, 32'd0);
    check("t6_idle_busy_a", 32'(busy_a), 32'd0);

    // Randomised levels and strobes.
    rs = 1'b0; rf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      if ($urandom_range(0, 59) == 0) rf = ~rf;
      step(rs, rf, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, rsel());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
